stage_sequencer: RTL and testbench

- Multicycle pipeline-stage sequencer for TinyCPU.
- Drives the `stage` and `stall` signals that per-stage register controls (issue register, PC, register file) consume.
- Owns the handshakes with instruction and data memory, a data-memory timeout watchdog, and a retired-instruction counter.
- Sits between core top level, memories, and the decoder.

---
 rtl/stage_sequencer_pkg.sv | 17 +
 rtl/stage_sequencer_mem_timeout_counter.sv | 30 +++
 rtl/stage_sequencer.sv | 137 +++++++++++++
 tb/tb_stage_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared stage encodings and widths for the TinyCPU multicycle sequencer.
// Consumers such as issue_register_control decode these stage values.
package stage_sequencer_pkg;

  localparam int unsigned STAGE_WIDTH = 3;
  localparam int unsigned TMO_W       = 8;

  typedef enum logic [STAGE_WIDTH-1:0] {
    STAGE_FETCH     = 3'd0,
    STAGE_ISSUE     = 3'd1,
    STAGE_EXECUTE   = 3'd2,
    STAGE_MEM       = 3'd3,
    STAGE_WRITEBACK = 3'd4,
    STAGE_HALT      = 3'd5
  } stage_e;

endpackage

// File: rtl/stage_sequencer_mem_timeout_counter.sv
// Saturating wait counter; expired is high once LIMIT-1 waiting cycles have elapsed,
// so the next waiting cycle is the LIMIT-th and trips the watchdog.
module mem_timeout_counter #(
  parameter int unsigned LIMIT = 16,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && (count_q != LAST)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: drives stage/stall, memory handshakes,
// the data-memory timeout watchdog and the retired-instruction counter.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned RET_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   imem_ready,
  input  logic                   dmem_ready,
  input  logic                   inst_is_mem,
  input  logic                   inst_is_halt,
  input  logic                   inst_writes_rd,
  input  logic                   ext_stall,
  output logic [STAGE_WIDTH-1:0] stage,
  output logic                   stall,
  output logic                   imem_req,
  output logic                   dmem_req,
  output logic                   pc_en,
  output logic                   rf_we,
  output logic                   halted,
  output logic                   bus_error,
  output logic [RET_W-1:0]       retired
);

  stage_e           state_q, state_d;
  logic             ready_pend_q, ready_pend_d;
  logic             bus_error_q;
  logic [RET_W-1:0] retired_q;
  logic             err_set;
  logic             ret_inc;
  logic             tmo_en;
  logic             tmo_clr;
  logic             tmo_expired;

  // State, pending-ready, sticky error and retire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STAGE_FETCH;
      ready_pend_q <= 1'b0;
      bus_error_q  <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      ready_pend_q <= ready_pend_d;
      if (err_set) bus_error_q <= 1'b1;
      if (ret_inc) retired_q <= retired_q + RET_W'(1);
    end
  end

  // Next-state and stage decode
  always_comb begin
    state_d      = state_q;
    ready_pend_d = ready_pend_q;
    err_set      = 1'b0;
    ret_inc      = 1'b0;
    tmo_en       = 1'b0;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    pc_en        = 1'b0;
    rf_we        = 1'b0;
    halted       = 1'b0;
    stall        = ext_stall;

    unique case (state_q)
      STAGE_FETCH: begin
        imem_req = 1'b1;
        stall    = ext_stall | (!imem_ready & !ready_pend_q);
        if (ext_stall) begin
          if (imem_ready) ready_pend_d = 1'b1;
        end else if (imem_ready || ready_pend_q) begin
          state_d      = STAGE_ISSUE;
          ready_pend_d = 1'b0;
        end
      end
      STAGE_ISSUE: begin
        if (!ext_stall) state_d = inst_is_halt ? STAGE_HALT : STAGE_EXECUTE;
      end
      STAGE_EXECUTE: begin
        if (!ext_stall) state_d = inst_is_mem ? STAGE_MEM : STAGE_WRITEBACK;
      end
      STAGE_MEM: begin
        dmem_req = 1'b1;
        stall    = ext_stall | (!dmem_ready & !ready_pend_q);
        if (ext_stall) begin
          if (dmem_ready) ready_pend_d = 1'b1;
        end else if (dmem_ready || ready_pend_q) begin
          state_d      = STAGE_WRITEBACK;
          ready_pend_d = 1'b0;
        end else begin
          // A waiting cycle; the one after the counter saturates is a bus error
          tmo_en = 1'b1;
          if (tmo_expired) begin
            state_d = STAGE_HALT;
            err_set = 1'b1;
          end
        end
      end
      STAGE_WRITEBACK: begin
        if (!ext_stall) begin
          pc_en   = 1'b1;
          rf_we   = inst_writes_rd;
          ret_inc = 1'b1;
          state_d = STAGE_FETCH;
        end
      end
      STAGE_HALT: begin
        halted       = 1'b1;
        stall        = 1'b0;
        ready_pend_d = 1'b0;
      end
      default: begin
        state_d = STAGE_FETCH;
      end
    endcase

    tmo_clr = (state_q != STAGE_MEM) || (state_d != STAGE_MEM);
  end

  mem_timeout_counter #(
    .LIMIT (MEM_TIMEOUT),
    .CNT_W (TMO_W)
  ) u_tmo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  assign stage     = STAGE_WIDTH'(state_q);
  assign bus_error = bus_error_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed self-checking bench for stage_sequencer with MEM_TIMEOUT = 4.
module tb_stage_sequencer;

  localparam int unsigned RET_W = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             imem_ready, dmem_ready, inst_is_mem, inst_is_halt;
  logic             inst_writes_rd, ext_stall;
  logic [2:0]       stage;
  logic             stall, imem_req, dmem_req, pc_en, rf_we, halted, bus_error;
  logic [RET_W-1:0] retired;

  int vectors = 0;
  int miscompares = 0;

  stage_sequencer #(.MEM_TIMEOUT(4), .RET_W(RET_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_ready     (imem_ready),
    .dmem_ready     (dmem_ready),
    .inst_is_mem    (inst_is_mem),
    .inst_is_halt   (inst_is_halt),
    .inst_writes_rd (inst_writes_rd),
    .ext_stall      (ext_stall),
    .stage          (stage),
    .stall          (stall),
    .imem_req       (imem_req),
    .dmem_req       (dmem_req),
    .pc_en          (pc_en),
    .rf_we          (rf_we),
    .halted         (halted),
    .bus_error      (bus_error),
    .retired        (retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_stage [4];
    exp_stage[0] = 1; exp_stage[1] = 2; exp_stage[2] = 4; exp_stage[3] = 0;

    rst_n = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; inst_is_mem = 1'b0;
    inst_is_halt = 1'b0; inst_writes_rd = 1'b0; ext_stall = 1'b0;
    #1;
    chk("rst_stage", 32'(stage), 0);
    chk("rst_imem_req", 32'(imem_req), 1);
    chk("rst_pc_en", 32'(pc_en), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_dmem_req", 32'(dmem_req), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_bus_error", 32'(bus_error), 0);
    chk("rst_retired", retired, 0);
    #1 rst_n = 1'b1;

    // Back-to-back ALU instructions, imem always ready
    imem_ready = 1'b1; inst_writes_rd = 1'b1;
    #1 chk("alu_fetch_stall", 32'(stall), 0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("alu_stage_%0d", i), 32'(stage), 32'(exp_stage[i % 4]));
      chk($sformatf("alu_pc_en_%0d", i), 32'(pc_en), (i % 4 == 2) ? 1 : 0);
      chk($sformatf("alu_rf_we_%0d", i), 32'(rf_we), (i % 4 == 2) ? 1 : 0);
    end
    chk("alu_retired", retired, 3);

    // Load: dmem_ready arrives on the 4th MEM cycle (counter already saturated)
    inst_is_mem = 1'b1;
    tick(); chk("ld_issue", 32'(stage), 1);
    tick(); chk("ld_exec", 32'(stage), 2);
    imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) dmem_ready = 1'b1;
      #1;
      chk($sformatf("ld_mem_stage_%0d", i), 32'(stage), 3);
      chk($sformatf("ld_dmem_req_%0d", i), 32'(dmem_req), 1);
      chk($sformatf("ld_stall_%0d", i), 32'(stall), (i == 3) ? 0 : 1);
    end
    tick(); dmem_ready = 1'b0;
    chk("ld_wb", 32'(stage), 4);
    chk("ld_wb_dmem_req", 32'(dmem_req), 0);
    chk("ld_bus_error", 32'(bus_error), 0);
    tick();
    chk("ld_fetch", 32'(stage), 0);
    chk("ld_retired", retired, 4);

    // Timeout: dmem_ready never comes
    imem_ready = 1'b1;
    tick(); tick(); imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("to_mem_%0d", i), 32'(stage), 3);
    end
    tick();
    chk("to_halt_stage", 32'(stage), 5);
    chk("to_bus_error", 32'(bus_error), 1);
    chk("to_halted", 32'(halted), 1);
    chk("to_dmem_req", 32'(dmem_req), 0);
    chk("to_imem_req", 32'(imem_req), 0);
    for (int i = 0; i < 100; i++) begin
      imem_ready = 1'($urandom_range(0, 1));
      dmem_ready = 1'($urandom_range(0, 1));
      ext_stall  = 1'($urandom_range(0, 1));
      inst_is_mem = 1'($urandom_range(0, 1));
      tick();
    end
    ext_stall = 1'b1; #1;
    chk("to_persist_stage", 32'(stage), 5);
    chk("to_persist_err", 32'(bus_error), 1);
    chk("to_persist_stall", 32'(stall), 0);
    chk("to_persist_retired", retired, 4);
    rst_n = 1'b0; #1;
    chk("to_rst_stage", 32'(stage), 0);
    chk("to_rst_err", 32'(bus_error), 0);
    chk("to_rst_halted", 32'(halted), 0);
    imem_ready = 1'b0; dmem_ready = 1'b0; inst_is_mem = 1'b0; ext_stall = 1'b0;
    #1 rst_n = 1'b1;

    // ext_stall freeze in FETCH with imem_ready pulsed on stall cycle 2
    tick();
    ext_stall = 1'b1; #1;
    chk("es_c1_stall", 32'(stall), 1);
    tick(); imem_ready = 1'b1; #1;
    chk("es_c2_stage", 32'(stage), 0);
    chk("es_c2_stall", 32'(stall), 1);
    for (int i = 3; i <= 5; i++) begin
      tick(); imem_ready = 1'b0; #1;
      chk($sformatf("es_c%0d_stage", i), 32'(stage), 0);
      chk($sformatf("es_c%0d_stall", i), 32'(stall), 1);
    end
    tick(); ext_stall = 1'b0; inst_writes_rd = 1'b0; #1;
    chk("es_release_stage", 32'(stage), 0);
    chk("es_release_stall", 32'(stall), 0);
    tick();
    chk("es_issue", 32'(stage), 1);
    tick(); tick();
    chk("es_wb", 32'(stage), 4);
    chk("es_wb_rf_we", 32'(rf_we), 0);
    chk("es_wb_pc_en", 32'(pc_en), 1);
    ext_stall = 1'b1; #1;
    chk("es_wb_frozen_pc_en", 32'(pc_en), 0);
    tick();
    chk("es_wb_frozen_stage", 32'(stage), 4);
    chk("es_wb_frozen_retired", retired, 0);
    ext_stall = 1'b0;
    tick();
    chk("es_wb_done", 32'(stage), 0);
    chk("es_retired", retired, 1);

    // Halt decoded in ISSUE
    imem_ready = 1'b1;
    tick(); inst_is_halt = 1'b1; imem_ready = 1'b0;
    tick();
    chk("hlt_stage", 32'(stage), 5);
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_retired", retired, 1);
    chk("hlt_reqs", {29'd0, imem_req, dmem_req, pc_en | rf_we}, 0);
    chk("hlt_bus_error", 32'(bus_error), 0);
    rst_n = 1'b0; inst_is_halt = 1'b0; inst_writes_rd = 1'b1;
    #2 rst_n = 1'b1;

    // Seven ALU instructions, then park in MEM under ext_stall, then reset
    imem_ready = 1'b1;
    for (int i = 0; i < 28; i++) tick();
    chk("rm_retired7", retired, 7);
    inst_is_mem = 1'b1;
    tick(); tick(); imem_ready = 1'b0;
    tick(); ext_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rm_mem_%0d", i), 32'(stage), 3);
      chk($sformatf("rm_dmem_req_%0d", i), 32'(dmem_req), 1);
    end
    #2 rst_n = 1'b0; #1;
    chk("rm_rst_stage", 32'(stage), 0);
    chk("rm_rst_retired", retired, 0);
    chk("rm_rst_dmem_req", 32'(dmem_req), 0);
    ext_stall = 1'b0; inst_is_mem = 1'b0; imem_ready = 1'b1;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rm_restart_%0d", i), 32'(stage), 32'(exp_stage[i]));
    end
    chk("rm_restart_retired", retired, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
